// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath, with a memory-stall watchdog.
// Optional build macro ILLEGAL_TRAP_EN routes unlisted opcodes to a TRAP state.
module multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       regDst,
  output logic       memToReg,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] pcSource,
  output logic [2:0] aluOp,
`ifdef ILLEGAL_TRAP_EN
  output logic       trapTaken,
`endif
  output logic       memErr,
  output logic       halted
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    JUMP   = 4'd10,
    HALT   = 4'd11,
    TRAP   = 4'd12
  } stateT;

  localparam logic [5:0] OP_RTYPE    = 6'b000000;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OP_LW       = 6'b100011;
  localparam logic [5:0] OP_SW       = 6'b101011;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] OP_J        = 6'b000010;
  localparam logic [5:0] FN_CLO      = 6'b100001;
  localparam logic [5:0] FN_CLZ      = 6'b100000;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  stateT            stateReg, stateNext;
  logic [CNT_W-1:0] wdCntReg, wdCntNext;
  logic             memErrReg, memErrNext;
  logic             waitState;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      stateReg  <= IDLE;
      wdCntReg  <= '0;
      memErrReg <= 1'b0;
    end else begin
      stateReg  <= stateNext;
      wdCntReg  <= wdCntNext;
      memErrReg <= memErrNext;
    end
  end

  assign memErr    = memErrReg;
  assign waitState = (stateReg == FETCH) || (stateReg == MEMRD) || (stateReg == MEMWR);

  always_comb begin
    stateNext   = stateReg;
    wdCntNext   = '0;
    memErrNext  = memErrReg;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    regDst      = 1'b0;
    memToReg    = 1'b0;
    regWrite    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    pcSource    = 2'b00;
    aluOp       = 3'b000;
    halted      = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    trapTaken   = 1'b0;
`endif

    case (stateReg)
      IDLE: stateNext = FETCH;

      FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        aluOp   = 3'b101;
        irWrite = memReady;
        pcWrite = memReady;
        if (memReady) stateNext = DECODE;
      end

      DECODE: begin
        aluSrcB = 2'b11;
        aluOp   = 3'b101;
        case (opcode)
          OP_RTYPE, OP_SPECIAL2: stateNext = EXEC;
          OP_LW, OP_SW:          stateNext = MEMADR;
          OP_BEQ:                stateNext = BRANCH;
          OP_J:                  stateNext = JUMP;
`ifdef ILLEGAL_TRAP_EN
          default:               stateNext = TRAP;
`else
          default:               stateNext = FETCH;
`endif
        endcase
      end

      MEMADR: begin
        aluSrcA   = 1'b1;
        aluSrcB   = 2'b10;
        aluOp     = (opcode == OP_SW) ? 3'b110 : 3'b101;
        stateNext = (opcode == OP_SW) ? MEMWR : MEMRD;
      end

      MEMRD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
        if (memReady) stateNext = MEMWB;
      end

      MEMWB: begin
        regWrite  = 1'b1;
        memToReg  = 1'b1;
        stateNext = FETCH;
      end

      MEMWR: begin
        memWrite = 1'b1;
        iorD     = 1'b1;
        if (memReady) stateNext = FETCH;
      end

      EXEC: begin
        aluSrcA = 1'b1;
        // SPECIAL2 count-leading ops get their own ALU codes; everything else defers to funct
        if (opcode == OP_SPECIAL2 && funct == FN_CLO)      aluOp = 3'b001;
        else if (opcode == OP_SPECIAL2 && funct == FN_CLZ) aluOp = 3'b010;
        else                                               aluOp = 3'b000;
        stateNext = ALUWB;
      end

      ALUWB: begin
        regWrite  = 1'b1;
        regDst    = 1'b1;
        stateNext = FETCH;
      end

      BRANCH: begin
        aluSrcA     = 1'b1;
        aluOp       = 3'b111;
        pcWriteCond = 1'b1;
        pcSource    = 2'b01;
        stateNext   = FETCH;
      end

      JUMP: begin
        pcWrite   = 1'b1;
        pcSource  = 2'b10;
        stateNext = FETCH;
      end

      HALT: halted = 1'b1;

`ifdef ILLEGAL_TRAP_EN
      TRAP: begin
        pcWrite   = 1'b1;
        pcSource  = 2'b11;
        trapTaken = 1'b1;
        stateNext = FETCH;
      end
`endif

      default: stateNext = IDLE;
    endcase

    // Watchdog: a completed access always wins over the timeout on the same cycle
    if (waitState && !memReady) begin
      if (wdCntReg == WD_LAST) begin
        stateNext  = HALT;
        memErrNext = 1'b1;
      end else begin
        wdCntNext = wdCntReg + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks every instruction class, stalls, watchdog and reset.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rstN;
  logic [5:0] opcode, funct;
  logic       memReady;
  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic       regDst, memToReg, regWrite, aluSrcA;
  logic [1:0] aluSrcB, pcSource;
  logic [2:0] aluOp;
  logic       memErr, halted;
`ifdef ILLEGAL_TRAP_EN
  logic       trapTaken;
`endif

  int nChecks = 0;
  int nPass   = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rstN(rstN), .opcode(opcode), .funct(funct), .memReady(memReady),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD),
    .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
    .regDst(regDst), .memToReg(memToReg), .regWrite(regWrite),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .pcSource(pcSource), .aluOp(aluOp),
`ifdef ILLEGAL_TRAP_EN
    .trapTaken(trapTaken),
`endif
    .memErr(memErr), .halted(halted)
  );

  // {pcWrite,pcWriteCond,iorD,memRead,memWrite,irWrite,regDst,memToReg,regWrite,aluSrcA,
  //  aluSrcB[1:0],pcSource[1:0],aluOp[2:0],memErr,halted}
  logic [18:0] obs;
  assign obs = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, regDst, memToReg,
                regWrite, aluSrcA, aluSrcB, pcSource, aluOp, memErr, halted};

  localparam logic [18:0] E_IDLE     = 19'd0;
  localparam logic [18:0] E_FETCH    = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,3'b101,1'b0,1'b0};
  localparam logic [18:0] E_FSTALL   = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,3'b101,1'b0,1'b0};
  localparam logic [18:0] E_DECODE   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,3'b101,1'b0,1'b0};
  localparam logic [18:0] E_ADR_LW   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,3'b101,1'b0,1'b0};
  localparam logic [18:0] E_ADR_SW   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,3'b110,1'b0,1'b0};
  localparam logic [18:0] E_MEMRD    = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b000,1'b0,1'b0};
  localparam logic [18:0] E_MEMWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,3'b000,1'b0,1'b0};
  localparam logic [18:0] E_MEMWR    = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b000,1'b0,1'b0};
  localparam logic [18:0] E_EXEC_R   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,3'b000,1'b0,1'b0};
  localparam logic [18:0] E_EXEC_CLO = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,3'b001,1'b0,1'b0};
  localparam logic [18:0] E_EXEC_CLZ = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,3'b010,1'b0,1'b0};
  localparam logic [18:0] E_ALUWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,3'b000,1'b0,1'b0};
  localparam logic [18:0] E_BRANCH   = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,3'b111,1'b0,1'b0};
  localparam logic [18:0] E_JUMP     = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,3'b000,1'b0,1'b0};
  localparam logic [18:0] E_HALT     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b000,1'b1,1'b1};
  localparam logic [18:0] E_TRAP     = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b11,3'b000,1'b0,1'b0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Inputs change on the falling edge; outputs are checked just after it.
  task automatic cyc(input string tag, input logic [18:0] exp);
    #1;
    check(tag, 32'(obs), 32'(exp));
    @(negedge clk);
  endtask

  task automatic afterNop();
`ifdef ILLEGAL_TRAP_EN
    #1;
    check("trapTaken", 32'(trapTaken), 32'd1);
    cyc("trap", E_TRAP);
`endif
  endtask

  task automatic startInstr(input string name, input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
    $display("[%0t] instr %s opcode=%b funct=%b", $time, name, op, fn);
  endtask

  initial begin
    rstN = 1'b0; memReady = 1'b1; opcode = '0; funct = '0;
    @(negedge clk); @(negedge clk);
    cyc("reset_idle", E_IDLE);
    rstN = 1'b1;
    cyc("idle", E_IDLE);

    startInstr("LW", 6'b100011, 6'b000000);
    cyc("lw_fetch", E_FETCH); cyc("lw_decode", E_DECODE); cyc("lw_memadr", E_ADR_LW);
    cyc("lw_memrd", E_MEMRD); cyc("lw_memwb", E_MEMWB);

    startInstr("SW", 6'b101011, 6'b000000);
    cyc("sw_fetch", E_FETCH); cyc("sw_decode", E_DECODE); cyc("sw_memadr", E_ADR_SW);
    cyc("sw_memwr", E_MEMWR);

    startInstr("CLO", 6'b011100, 6'b100001);
    cyc("clo_fetch", E_FETCH); cyc("clo_decode", E_DECODE); cyc("clo_exec", E_EXEC_CLO);
    cyc("clo_aluwb", E_ALUWB);

    startInstr("CLZ", 6'b011100, 6'b100000);
    cyc("clz_fetch", E_FETCH); cyc("clz_decode", E_DECODE); cyc("clz_exec", E_EXEC_CLZ);
    cyc("clz_aluwb", E_ALUWB);

    startInstr("SPECIAL2_MUL", 6'b011100, 6'b000010);
    cyc("sp2_fetch", E_FETCH); cyc("sp2_decode", E_DECODE); cyc("sp2_exec", E_EXEC_R);
    cyc("sp2_aluwb", E_ALUWB);

    startInstr("RTYPE_ADD", 6'b000000, 6'b100000);
    cyc("r_fetch", E_FETCH); cyc("r_decode", E_DECODE); cyc("r_exec", E_EXEC_R);
    cyc("r_aluwb", E_ALUWB);

    startInstr("BEQ", 6'b000100, 6'b000000);
    cyc("beq_fetch", E_FETCH); cyc("beq_decode", E_DECODE); cyc("beq_branch", E_BRANCH);

    startInstr("J", 6'b000010, 6'b000000);
    cyc("j_fetch", E_FETCH); cyc("j_decode", E_DECODE); cyc("j_jump", E_JUMP);

    startInstr("ADDI_NOP", 6'b001000, 6'b000000);
    cyc("nop_fetch", E_FETCH); cyc("nop_decode", E_DECODE); afterNop();

    startInstr("LW_STALL", 6'b100011, 6'b000000);
    cyc("stl_fetch", E_FETCH); cyc("stl_decode", E_DECODE); cyc("stl_memadr", E_ADR_LW);
    memReady = 1'b0;
    for (int i = 0; i < 3; i++) cyc("stl_memrd_wait", E_MEMRD);
    memReady = 1'b1;
    cyc("stl_memrd_done", E_MEMRD); cyc("stl_memwb", E_MEMWB);

    startInstr("LW_RESET", 6'b100011, 6'b000000);
    cyc("rr_fetch", E_FETCH); cyc("rr_decode", E_DECODE); cyc("rr_memadr", E_ADR_LW);
    memReady = 1'b0;
    cyc("rr_memrd", E_MEMRD);
    rstN = 1'b0;
    @(negedge clk);
    cyc("rr_reset1", E_IDLE);
    rstN = 1'b1; memReady = 1'b1;
    cyc("rr_reset2", E_IDLE);
    cyc("rr_fetch_after", E_FETCH);

    startInstr("TIMEOUT_EDGE", 6'b001000, 6'b000000);
    cyc("te_decode", E_DECODE); afterNop();
    memReady = 1'b0;
    for (int i = 0; i < 3; i++) cyc("te_fetch_wait", E_FSTALL);
    memReady = 1'b1;
    cyc("te_fetch_last", E_FETCH);
    cyc("te_decode_noerr", E_DECODE); afterNop();

    startInstr("TIMEOUT_HALT", 6'b001000, 6'b000000);
    memReady = 1'b0;
    for (int i = 0; i < 4; i++) cyc("to_fetch_wait", E_FSTALL);
    cyc("to_halt", E_HALT);
    memReady = 1'b1;
    cyc("to_halt_hold1", E_HALT); cyc("to_halt_hold2", E_HALT);

    rstN = 1'b0;
    @(negedge clk);
    cyc("halt_reset", E_IDLE);
    rstN = 1'b1;
    cyc("halt_idle", E_IDLE);
    cyc("halt_refetch", E_FETCH);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle MIPS datapath; sits directly upstream of the ALU control stage.
- Decodes the latched instruction opcode and funct fields and sequences fetch, decode, execute, memory and writeback.
- Drives the 3-bit aluOp consumed by the ALU control stage, plus all datapath enables and mux selects.
- Waits on a memory-ready handshake; a watchdog halts the core on a stalled memory.

Parameters:
- TIMEOUT, 16, max consecutive memReady=0 cycles in a wait state before halting (2..255).
- CNT_W, 8, width of the watchdog counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock, rising edge
- rstN  in  1  synchronous active-low reset
- opcode  in  6  instr[31:26], stable from the cycle after FETCH completes
- funct  in  6  instr[5:0]
- memReady  in  1  memory access completes this cycle
- pcWrite  out  1  unconditional PC load
- pcWriteCond  out  1  PC load if ALU zero
- iorD  out  1  memory address: 0=PC, 1=ALUOut
- memRead, memWrite  out  1 each  memory strobes
- irWrite  out  1  instruction register load
- regDst  out  1  1=rd, 0=rt
- memToReg  out  1  writeback source: 1=MDR
- regWrite  out  1  register file write
- aluSrcA  out  1  0=PC, 1=A
- aluSrcB  out  2  00=B, 01=const 4, 10=sign-extended imm, 11=imm<<2
- pcSource  out  2  00=ALU, 01=ALUOut, 10=jump target, 11=trap vector
- aluOp  out  3  000 R-type/funct, 001 CLO, 010 CLZ, 101 add (LW/addr), 110 SW, 111 BEQ subtract
- memErr  out  1  sticky watchdog error
- halted  out  1  FSM is in HALT

Behaviour:
- Registered 4-bit state. Outputs are decoded combinationally from state, opcode, funct and memReady. Any output not listed for a state is 0.
- Reset: rstN=0 at a clk edge puts the state in IDLE, clears memErr and clears the watchdog counter. In IDLE all outputs are 0. Reset has priority in every state, including mid-stall and HALT.
- IDLE: next state is FETCH.
- FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=101, pcSource=00. irWrite and pcWrite equal memReady. Stay while memReady=0; go to DECODE when memReady=1.
- DECODE: aluSrcA=0, aluSrcB=11, aluOp=101. Next state by opcode:
  - 000000 or 011100 -> EXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - other -> FETCH (NOP)
- MEMADR: aluSrcA=1, aluSrcB=10. aluOp=101 for LW, 110 for SW. Next state: LW -> MEMRD, SW -> MEMWR.
- MEMRD: memRead=1, iorD=1. Hold until memReady=1, then MEMWB.
- MEMWB: regWrite=1, memToReg=1, regDst=0. Next state FETCH.
- MEMWR: memWrite=1, iorD=1. Hold until memReady=1, then FETCH.
- EXEC: aluSrcA=1, aluSrcB=00. aluOp:
  - opcode 000000 -> 000
  - opcode 011100, funct 100001 -> 001 (CLO)
  - opcode 011100, funct 100000 -> 010 (CLZ)
  - opcode 011100, other funct -> 000
  - Next state ALUWB.
- ALUWB: regWrite=1, regDst=1, memToReg=0. Next state FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=111, pcWriteCond=1, pcSource=01. Next state FETCH.
- JUMP: pcWrite=1, pcSource=10. Next state FETCH.
- Cycle counts with memReady=1 throughout, counted FETCH to FETCH: LW 5, SW 4, R-type/CLO/CLZ 4, BEQ 3, J 3, NOP 2.
- Watchdog:
  - The counter increments each cycle spent in FETCH, MEMRD or MEMWR with memReady=0.
  - It clears when memReady=1 or when the state leaves those states.
  - When the counter equals TIMEOUT-1 and memReady=0: next state HALT, memErr set.
  - If memReady=1 in that same cycle, the normal transition wins and memErr stays 0.
- HALT: all strobes 0, halted=1. Exit only by reset.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: an unlisted opcode in DECODE goes to TRAP. TRAP drives pcWrite=1, pcSource=11, and asserts output trapTaken=1 for that one cycle. Next state FETCH.
- Undefined: an unlisted opcode goes to FETCH as a NOP. The trapTaken port does not exist.

Test Plan:
- Reset: rstN=0 for 2 edges mid-MEMRD -> state IDLE, all outputs 0, memErr=0. Release -> FETCH next cycle with memRead=1, aluOp=101.
- LW 100011, memReady=1 -> FETCH, DECODE, MEMADR (aluOp=101, aluSrcB=10), MEMRD (iorD=1), MEMWB (regWrite=1, memToReg=1); back in FETCH after 5 cycles.
- CLO: opcode 011100, funct 100001 -> EXEC aluOp=001, then ALUWB regDst=1, regWrite=1. Same with funct 100000 -> aluOp=010. SW 101011 -> MEMADR aluOp=110, then memWrite=1.
- BEQ 000100 -> BRANCH: aluOp=111, pcWriteCond=1, pcSource=01, pcWrite=0; FETCH after 3 cycles.
- Stall: memReady=0 for 3 cycles in MEMRD -> memRead=1, iorD=1 held; MEMWB on the cycle after memReady=1; memErr=0.
- Timeout, TIMEOUT=4: memReady=0 in FETCH -> HALT after 4 cycles, memErr=1, halted=1. memReady=1 on the 4th cycle -> DECODE, memErr=0.
